sevenseg_scan_driver: RTL
=========================

// Module: sevenseg_scan_driver
// PURPOSE
//  Binary-to-multiplexed-7-segment display driver: latches an unsigned binary value, converts it
//  to BCD sequentially (double dabble), and scans N common-terminal digits at a programmable rate
//  with inter-digit blanking. Adds leading-zero suppression and overflow indication.
//  Sits between score/counter logic and the board's 7-seg pins.
// PARAMETERS
//  N_DIGITS     3      number of displayed digits (1..6)
//  BIN_W        11     width of binary input value
//  SCAN_DIV     10000  clock cycles per digit slot (1 kHz digit rate at 10 MHz); must be > BLANK_CYC
//  BLANK_CYC    200    cycles at start of each slot with all digits off (anti-ghosting)
//  SEG_ACT_LOW  1      1: seg outputs active-low; 0: active-high
//  DIG_ACT_LOW  0      1: digit enables active-low; 0: active-high
//  LZ_SUPPRESS  1      1: blank leading zeros (digit 0 always shown)
// PORTS
//  CLOCK10M  in   1         system clock
//  RESET     in   1         synchronous, active-high reset
//  value     in   BIN_W     binary value to display, sampled when load=1 and busy=0
//  load      in   1         request to convert/display value
//  busy      out  1         conversion in progress; load ignored while high
//  overflow  out  1         displayed value >= 10**N_DIGITS (dashes shown)
//  seg       out  8         {dp,g,f,e,d,c,b,a}; dp driven inactive
//  digit     out  N_DIGITS  digit enable, bit 0 = least significant digit
// BEHAVIOUR
//  Reset: busy=0, overflow=0, seg and digit inactive, scan index=0, slot counter=0, display
//   register=all zeros (shows "0"; LZ_SUPPRESS leaves only digit 0 lit). Reset mid-conversion
//   abandons it; no partial result reaches the display register.
//  Load: load=1 & busy=0 at edge E captures value; busy=1 from E. Conversion runs BIN_W shift
//   steps (add-3 when BCD nibble >= 5, then shift). On edge E+BIN_W+1 display register and overflow
//   update atomically and busy falls. load while busy has no effect (no queueing).
//   load=1 on the same edge busy falls is ignored; accepted next edge.
//  BCD holds N_DIGITS+1 nibbles internally; overflow=1 iff top nibble nonzero or a carry out occurs.
//   Overflow display: every digit shows '-' (segment g only), LZ_SUPPRESS ignored.
//  Scan: slot counter 0..SCAN_DIV-1, wraps; at wrap scan index increments, N_DIGITS-1 wraps to 0.
//   Counter < BLANK_CYC: all digit enables inactive, seg inactive. Otherwise exactly one digit
//   enable active (index) and seg = pattern of that nibble. Outputs registered (1-cycle latency
//   from counter/index). Scan free-runs independent of load/busy; display-register updates take
//   effect at the next visible cycle without restarting the scan.
//  Leading zeros: digit i blanked (seg inactive, enable still active) iff LZ_SUPPRESS, i>0 and
//   all nibbles i..N_DIGITS-1 are zero.
//  Nibble >9 cannot occur; decoder default = all segments off.
//  Polarity applied only at output register: seg = SEG_ACT_LOW ? ~pat : pat (same for digit).
// STRUCTURE
//  Package sevenseg_pkg: SEG_PAT[0..9] active-high {g..a} constants (0=7'h3F,1=06,2=5B,3=4F,
//   4=66,5=6D,6=7D,7=07,8=7F,9=6F), SEG_DASH=7'h40, SEG_OFF=7'h00, function seg_of(nibble).
//  Sub-module bin2bcd_seq (params BIN_W, N_NIB): start/value in, busy/done/bcd out, double dabble
//   FSM IDLE->SHIFT(BIN_W cycles)->DONE->IDLE. Top holds display register, scan counter, output regs.
// TESTING  (sim params SCAN_DIV=8, BLANK_CYC=2, N_DIGITS=3, BIN_W=11, polarities 0)
//  Reset then scan: digit cycles 001->010->100 every 8 clk, off 2 clk each; digit0 seg=0x3F, others 0x00.
//  load value=407: busy high 12 edges; then digits show 0x66,0x3F,0x07 (4,0,7); no LZ blanking.
//  load value=5: digit0=0x6D, digits 1,2 seg=0x00 with enables active; LZ_SUPPRESS=0 -> 0x3F.
//  load value=1000 then 2047: overflow=1, all digits 0x40; then load 999 -> overflow=0, "999".
//  load pulsed every cycle while busy: only first value displayed; load on busy-fall edge ignored.
//  RESET asserted at step 5 of conversion: busy=0 next edge, display "0", outputs per reset spec.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants, state encoding and the segment decoder for the
// multiplexed seven-segment scan driver.
package sevenseg_pkg;

  // Active-high {g,f,e,d,c,b,a} patterns for decimal digits 0..9 (index 0 rightmost).
  localparam logic [9:0][6:0] SEG_PAT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Sequential binary-to-BCD converter states.
  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_DONE  = 2'd2
  } bcd_state_e;

  // Decode one BCD nibble; codes above 9 never occur and fall back to dark.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_PAT[0];
      4'd1:    pat = SEG_PAT[1];
      4'd2:    pat = SEG_PAT[2];
      4'd3:    pat = SEG_PAT[3];
      4'd4:    pat = SEG_PAT[4];
      4'd5:    pat = SEG_PAT[5];
      4'd6:    pat = SEG_PAT[6];
      4'd7:    pat = SEG_PAT[7];
      4'd8:    pat = SEG_PAT[8];
      4'd9:    pat = SEG_PAT[9];
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sevenseg_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock.
// A start in IDLE captures the value; BIN_W shift steps follow, then one
// DONE cycle during which bcd_o/carry_o hold the final result.
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int BIN_W = 11,
  parameter int N_NIB = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [BIN_W-1:0]     value_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*N_NIB-1:0]   bcd_o,
  output logic                 carry_o
);

  localparam int STEP_W = $clog2(BIN_W + 1);

  bcd_state_e              state_q, state_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4*N_NIB-1:0]      bcd_q, bcd_d;
  logic                    carry_q, carry_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [4*N_NIB-1:0]      adj_s;

  // Next-state logic: capture on start, add-3 then shift in SHIFT, hand off in DONE.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    step_d  = step_q;
    adj_s   = bcd_q;
    for (int k = 0; k < N_NIB; k++) begin
      adj_s[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? (bcd_q[4*k +: 4] + 4'd3) : bcd_q[4*k +: 4];
    end
    case (state_q)
      BCD_IDLE: begin
        if (start_i) begin
          state_d = BCD_SHIFT;
          bin_d   = value_i;
          bcd_d   = '0;
          carry_d = 1'b0;
          step_d  = '0;
        end else begin
          state_d = BCD_IDLE;
        end
      end
      BCD_SHIFT: begin
        // A set MSB after adjustment would be lost off the top: remember it as overflow.
        carry_d = carry_q | adj_s[4*N_NIB-1];
        bcd_d   = {adj_s[4*N_NIB-2:0], bin_q[BIN_W-1]};
        bin_d   = bin_q << 1;
        step_d  = step_q + STEP_W'(1);
        if (step_q == STEP_W'(BIN_W - 1)) begin
          state_d = BCD_DONE;
        end else begin
          state_d = BCD_SHIFT;
        end
      end
      BCD_DONE: begin
        state_d = BCD_IDLE;
      end
      default: begin
        state_d = BCD_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BCD_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      step_q  <= step_d;
    end
  end

  assign busy_o  = (state_q != BCD_IDLE);
  assign done_o  = (state_q == BCD_DONE);
  assign bcd_o   = bcd_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: converts a loaded binary value to BCD,
// holds it in a display register and scans the digits with blanking gaps,
// leading-zero suppression and a dash pattern on overflow.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int N_DIGITS    = 3,
  parameter int BIN_W       = 11,
  parameter int SCAN_DIV    = 10000,
  parameter int BLANK_CYC   = 200,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b0,
  parameter bit LZ_SUPPRESS = 1'b1
) (
  input  logic                CLOCK10M,
  input  logic                RESET,
  input  logic [BIN_W-1:0]    value,
  input  logic                load,
  output logic                busy,
  output logic                overflow,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] digit
);

  localparam int N_NIB = N_DIGITS + 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                   cvt_busy_s;
  logic                   cvt_done_s;
  logic [4*N_NIB-1:0]     cvt_bcd_s;
  logic                   cvt_carry_s;

  logic [4*N_DIGITS-1:0]  disp_q;
  logic                   ovf_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [7:0]             seg_q, seg_d;
  logic [N_DIGITS-1:0]    dig_q, dig_d;

  logic [3:0]             nib_s;
  logic                   upper_zero_s;
  logic [6:0]             pat_s;
  logic [N_DIGITS-1:0]    onehot_s;

  bin2bcd_seq #(
    .BIN_W (BIN_W),
    .N_NIB (N_NIB)
  ) u_bin2bcd (
    .clk_i   (CLOCK10M),
    .rst_i   (RESET),
    .start_i (load & ~cvt_busy_s),
    .value_i (value),
    .busy_o  (cvt_busy_s),
    .done_o  (cvt_done_s),
    .bcd_o   (cvt_bcd_s),
    .carry_o (cvt_carry_s)
  );

  // Display register and overflow flag update together when a conversion completes.
  always_ff @(posedge CLOCK10M) begin
    if (RESET) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (cvt_done_s) begin
      disp_q <= cvt_bcd_s[4*N_DIGITS-1:0];
      ovf_q  <= cvt_carry_s | (cvt_bcd_s[4*N_NIB-1:4*N_DIGITS] != 4'd0);
    end else begin
      disp_q <= disp_q;
      ovf_q  <= ovf_q;
    end
  end

  // Free-running slot counter; the digit index advances on each slot wrap.
  always_ff @(posedge CLOCK10M) begin
    if (RESET) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : (idx_q + IDX_W'(1));
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      idx_q <= idx_q;
    end
  end

  // Select the active nibble, decide blanking and build the polarity-corrected outputs.
  always_comb begin
    nib_s        = 4'd0;
    upper_zero_s = 1'b1;
    onehot_s     = '0;
    pat_s        = SEG_OFF;
    seg_d        = 8'h00;
    dig_d        = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      nib_s        = (IDX_W'(k) == idx_q) ? disp_q[4*k +: 4] : nib_s;
      onehot_s[k]  = (IDX_W'(k) == idx_q);
      upper_zero_s = upper_zero_s & ~((IDX_W'(k) >= idx_q) & (disp_q[4*k +: 4] != 4'd0));
    end
    if (cnt_q < CNT_W'(BLANK_CYC)) begin
      pat_s = SEG_OFF;
      dig_d = '0;
    end else begin
      dig_d = onehot_s;
      if (ovf_q) begin
        pat_s = SEG_DASH;
      end else if (LZ_SUPPRESS && (idx_q != '0) && upper_zero_s) begin
        pat_s = SEG_OFF;
      end else begin
        pat_s = seg_of(nib_s);
      end
    end
    seg_d = SEG_ACT_LOW ? ~{1'b0, pat_s} : {1'b0, pat_s};
    dig_d = DIG_ACT_LOW ? ~dig_d : dig_d;
  end

  // Output registers; reset drives every segment and digit enable inactive.
  always_ff @(posedge CLOCK10M) begin
    if (RESET) begin
      seg_q <= SEG_ACT_LOW ? 8'hFF : 8'h00;
      dig_q <= DIG_ACT_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign busy     = cvt_busy_s;
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign digit    = dig_q;

endmodule
